// File: rtl/alu_issuer_if.sv
// ---------------------------------------------------------------------------
// alu_issuer_if
// Bundles the command byte stream, the ALU operand/result bus and the result
// handshake of alu_issuer.
//   slave  : used by alu_issuer (consumes commands, drives the ALU, produces
//            results)
//   master : used by the environment (command source, ALU, result sink)
// Signals:
//   in_valid/in_ready/in_data    command bytes: opcode, then A, then B
//   alu_a/alu_b/alu_sel          operands and opcode to the 8-bit ALU
//   alu_result/alu_carry         combinational ALU response
//   res_valid/res_ready          result handshake
//   res_data/res_carry           captured result and carry/borrow
//   err                          one-cycle pulse on a rejected opcode byte
// ---------------------------------------------------------------------------
interface alu_issuer_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [2:0] alu_sel;
   logic [7:0] alu_result;
   logic       alu_carry;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic       res_carry;
   logic       err;

   modport slave (
      input  in_valid, in_data, alu_result, alu_carry, res_ready,
      output in_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_carry, err
   );

   modport master (
      output in_valid, in_data, alu_result, alu_carry, res_ready,
      input  in_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_carry, err
   );
endinterface

// File: rtl/alu_issuer.sv
// ---------------------------------------------------------------------------
// alu_issuer
// Collects a three-byte command (opcode, A, B) from a valid/ready byte
// stream, presents it to an external 8-bit ALU, waits SETTLE_CYCLES for the
// ALU to settle, captures result and carry, and offers them on a
// valid/ready result port.
// Parameters:
//   SETTLE_CYCLES (1..15)  cycles operands are held before the result is
//                          sampled; B-acceptance to res_valid is
//                          SETTLE_CYCLES+1 cycles
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_issuer_if.slave (command stream, ALU bus, result, err)
// Configuration:
//   ALU_ISSUER_OPCHECK_EN  when defined, opcode bytes with in_data[7:3] != 0
//                          are dropped and err pulses for one cycle; when
//                          undefined the upper bits are ignored and err is 0
// ---------------------------------------------------------------------------
module alu_issuer #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input logic        clk,
   input logic        rst_n,
   alu_issuer_if.slave bus
);

   typedef enum logic [2:0] {
      GET_OP = 3'd0,
      GET_A  = 3'd1,
      GET_B  = 3'd2,
      EXEC   = 3'd3,
      RESP   = 3'd4
   } state_t;

   state_t     state;
   state_t     next_state;

   logic       cmd_ready;
   logic       resp_valid;
   logic       err_pulse;
   logic [2:0] sel;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic [7:0] result;
   logic       carry;
   logic [3:0] cnt;

   logic       accept;
   logic       op_bad;
   logic       in_ready_nxt;
   logic       res_valid_nxt;
   logic       err_nxt;
   logic       load_sel;
   logic       load_a;
   logic       load_b;
   logic       capture;

   // in_ready is a register that is only high in GET states, so a byte can
   // never be taken in EXEC or RESP.
   assign accept = bus.in_valid & cmd_ready;

`ifdef ALU_ISSUER_OPCHECK_EN
   assign op_bad = (bus.in_data[7:3] != 5'd0);
`else
   logic unused_opcode_hi;
   assign op_bad           = 1'b0;
   assign unused_opcode_hi = ^bus.in_data[7:3];
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= GET_OP;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         GET_OP: begin
            if (accept && !op_bad) next_state = GET_A;
            else                   next_state = GET_OP;
         end
         GET_A: begin
            if (accept) next_state = GET_B;
            else        next_state = GET_A;
         end
         GET_B: begin
            if (accept) next_state = EXEC;
            else        next_state = GET_B;
         end
         EXEC: begin
            if (cnt == 4'd0) next_state = RESP;
            else             next_state = EXEC;
         end
         RESP: begin
            if (resp_valid && bus.res_ready) next_state = GET_OP;
            else                             next_state = RESP;
         end
         default: next_state = GET_OP;
      endcase
   end

   // Output logic: next values of the registered outputs and datapath enables.
   always_comb begin
      in_ready_nxt  = 1'b0;
      res_valid_nxt = 1'b0;
      err_nxt       = 1'b0;
      load_sel      = 1'b0;
      load_a        = 1'b0;
      load_b        = 1'b0;
      capture       = 1'b0;

      case (next_state)
         GET_OP, GET_A, GET_B: in_ready_nxt = 1'b1;
         RESP:                 res_valid_nxt = 1'b1;
         default:              in_ready_nxt = 1'b0;
      endcase

      if (accept) begin
         case (state)
            GET_OP: begin
               if (op_bad) err_nxt  = 1'b1;
               else        load_sel = 1'b1;
            end
            GET_A:   load_a = 1'b1;
            GET_B:   load_b = 1'b1;
            default: load_a = 1'b0;
         endcase
      end else begin
         load_a = 1'b0;
      end

      // The counter sits at 0 for one whole EXEC cycle before sampling, which
      // yields SETTLE_CYCLES+1 cycles from B acceptance to res_valid.
      if ((state == EXEC) && (cnt == 4'd0)) capture = 1'b1;
      else                                  capture = 1'b0;
   end

   // Registered outputs, operand/result registers and settle counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_ready  <= 1'b0;
         resp_valid <= 1'b0;
         err_pulse  <= 1'b0;
         sel        <= 3'd0;
         op_a       <= 8'd0;
         op_b       <= 8'd0;
         result     <= 8'd0;
         carry      <= 1'b0;
         cnt        <= 4'd0;
      end else begin
         cmd_ready  <= in_ready_nxt;
         resp_valid <= res_valid_nxt;
         err_pulse  <= err_nxt;
         if (load_sel) sel  <= bus.in_data[2:0];
         if (load_a)   op_a <= bus.in_data;
         if (load_b) begin
            op_b <= bus.in_data;
            cnt  <= 4'(SETTLE_CYCLES);
         end else if ((state == EXEC) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
         if (capture) begin
            result <= bus.alu_result;
            carry  <= bus.alu_carry;
         end
      end
   end

   assign bus.in_ready  = cmd_ready;
   assign bus.res_valid = resp_valid;
   assign bus.err       = err_pulse;
   assign bus.alu_sel   = sel;
   assign bus.alu_a     = op_a;
   assign bus.alu_b     = op_b;
   assign bus.res_data  = result;
   assign bus.res_carry = carry;

endmodule
